// File: rtl/aes_dw_ctr_pkg.sv
// Shared definitions for the AES-128 counter-mode keystream generator:
// default widths, FSM states, S-box and round-constant tables.
package aes_dw_ctr_pkg;

    localparam int AESWidthDef       = 128;
    localparam int IVEntropyWidthDef = 64;

    typedef enum logic [1:0] {
        KEY_WAIT,
        KEY_EXPAND,
        RUN
    } state_e;

    // Row-major FIPS-197 S-box; element 0 sits in the most significant byte.
    localparam logic [0:255][7:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };

    localparam logic [10:1][7:0] RCON = 80'h361b8040201008040201;

    function automatic logic [7:0] sbox(input logic [7:0] b);
        return SBOX[b];
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
    endfunction

endpackage

// File: rtl/aes_dw_ctr_if.sv
// IV / key / keystream bundle between the generator and its user.
interface aes_dw_ctr_if
    import aes_dw_ctr_pkg::*;
#(
    parameter int W              = 4,
    parameter int IVEntropyWidth = IVEntropyWidthDef,
    parameter int AESWidth       = AESWidthDef
);
    logic [IVEntropyWidth-1:0] DataIn;
    logic                      DataInValid;
    logic                      DataInReady;
    logic [AESWidth-1:0]       Key;
    logic                      KeyValid;
    logic                      KeyReady;
    logic [W*AESWidth-1:0]     DataOut;
    logic                      DataOutValid;

    modport slave (
        input  DataIn, DataInValid, Key, KeyValid,
        output DataInReady, KeyReady, DataOut, DataOutValid
    );

    modport master (
        output DataIn, DataInValid, Key, KeyValid,
        input  DataInReady, KeyReady, DataOut, DataOutValid
    );
endinterface

// File: rtl/aes_dw_ctr_enc_pipe.sv
// Fully pipelined AES-128 encryptor: whitening, 10 rounds, then a held output
// register. Round keys are supplied precomputed and must stay stable in use.
module aes128_enc_pipe
    import aes_dw_ctr_pkg::*;
#(
    parameter int D = 12
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              vld_i,
    input  logic [127:0]      blk_i,
    input  logic [10:0][127:0] rk_i,
    output logic              vld_o,
    output logic [127:0]      blk_o
);
    localparam int NRND = 10;

    function automatic logic [7:0] xt(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [127:0] aes_round(input logic [127:0] s, input logic [127:0] k,
                                               input logic last);
        logic [7:0]   a [16];
        logic [7:0]   t [16];
        logic [7:0]   b0, b1, b2, b3;
        logic [127:0] r;
        for (int i = 0; i < 16; i++) a[i] = sbox(s[127-8*i -: 8]);
        for (int c = 0; c < 4; c++)
            for (int rr = 0; rr < 4; rr++) t[4*c+rr] = a[4*((c+rr)%4)+rr];
        for (int c = 0; c < 4; c++) begin
            b0 = t[4*c]; b1 = t[4*c+1]; b2 = t[4*c+2]; b3 = t[4*c+3];
            if (!last) begin
                t[4*c]   = xt(b0) ^ xt(b1) ^ b1 ^ b2 ^ b3;
                t[4*c+1] = b0 ^ xt(b1) ^ xt(b2) ^ b2 ^ b3;
                t[4*c+2] = b0 ^ b1 ^ xt(b2) ^ xt(b3) ^ b3;
                t[4*c+3] = xt(b0) ^ b0 ^ b1 ^ b2 ^ xt(b3);
            end
        end
        r = '0;
        for (int i = 0; i < 16; i++) r[127-8*i -: 8] = t[i];
        return r ^ k;
    endfunction

    logic [D-1:0] vld_pipe_q;
    logic [127:0] st_q [1:D-1];
    logic [127:0] st_d [1:D-1];
    logic [127:0] out_q;

    // Stage 1 whitens, stages 2..11 run rounds 1..10, anything deeper just delays.
    always_comb begin
        st_d[1] = blk_i ^ rk_i[0];
        for (int k = 2; k <= D-1; k++)
            st_d[k] = (k <= NRND+1) ? aes_round(st_q[k-1], rk_i[k-1], k == NRND+1) : st_q[k-1];
    end

    always_ff @(posedge clk_i) begin
        st_q <= st_d;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            vld_pipe_q <= '0;
            out_q      <= '0;
        end else begin
            vld_pipe_q <= {vld_pipe_q[D-2:0], vld_i};
            if (vld_pipe_q[D-2]) out_q <= st_q[D-1];
        end
    end

    assign vld_o = vld_pipe_q[D-1];
    assign blk_o = out_q;

endmodule

// File: rtl/aes_dw_ctr.sv
// AES-128 counter-mode pad generator: W keystream blocks per IV, one IV per
// cycle, fixed latency D. The key is loaded once per reset and expanded in place.
module aes_dw_ctr
    import aes_dw_ctr_pkg::*;
#(
    parameter int W              = 4,
    parameter int D              = 12,
    parameter int IVEntropyWidth = IVEntropyWidthDef,
    parameter int AESWidth       = AESWidthDef
) (
    input  logic         Clock,
    input  logic         Reset,
    aes_dw_ctr_if.slave  bus
);
    localparam int CtrW = AESWidth - IVEntropyWidth;

    function automatic logic [127:0] next_rk(input logic [127:0] k, input logic [7:0] rc);
        logic [31:0] w0, w1, w2, w3, t;
        {w0, w1, w2, w3} = k;
        t  = sub_word({w3[23:0], w3[31:24]}) ^ {rc, 24'h0};
        w0 = w0 ^ t;
        w1 = w1 ^ w0;
        w2 = w2 ^ w1;
        w3 = w3 ^ w2;
        return {w0, w1, w2, w3};
    endfunction

    state_e                      state_q, state_d;
    logic [3:0]                  rnd_q, rnd_d;
    logic                        en_q;
    logic                        key_ld, rk_ld, key_ready, in_vld;
    logic [10:0][AESWidth-1:0]   rk_q;
    logic [AESWidth-1:0]         rk_next;
    logic [W-1:0]                lane_vld;
    logic [W-1:0][AESWidth-1:0]  lane_blk;

    // en_q keeps KeyReady low until the first edge after reset release.
    assign key_ready = en_q && (state_q == KEY_WAIT);
    assign in_vld    = bus.DataInValid && (state_q == RUN);
    assign rk_next   = next_rk(rk_q[rnd_q - 4'd1], RCON[rnd_q]);

    always_comb begin
        state_d = state_q;
        rnd_d   = rnd_q;
        key_ld  = 1'b0;
        rk_ld   = 1'b0;
        unique case (state_q)
            KEY_WAIT: begin
                if (bus.KeyValid && key_ready) begin
                    state_d = KEY_EXPAND;
                    rnd_d   = 4'd1;
                    key_ld  = 1'b1;
                end
            end
            KEY_EXPAND: begin
                rk_ld = 1'b1;
                if (rnd_q == 4'd10) state_d = RUN;
                else                rnd_d   = rnd_q + 4'd1;
            end
            RUN: ;
            default: state_d = KEY_WAIT;
        endcase
    end

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state_q <= KEY_WAIT;
            rnd_q   <= '0;
            en_q    <= 1'b0;
            rk_q    <= '0;
        end else begin
            state_q <= state_d;
            rnd_q   <= rnd_d;
            en_q    <= 1'b1;
            if (key_ld) rk_q[0]     <= bus.Key;
            if (rk_ld)  rk_q[rnd_q] <= rk_next;
        end
    end

    for (genvar j = 0; j < W; j++) begin : g_lane
        logic [AESWidth-1:0] ctr_blk;
        assign ctr_blk = {bus.DataIn, CtrW'(j)};

        aes128_enc_pipe #(.D(D)) u_pipe (
            .clk_i  (Clock),
            .rst_ni (Reset),
            .vld_i  (in_vld),
            .blk_i  (ctr_blk),
            .rk_i   (rk_q),
            .vld_o  (lane_vld[j]),
            .blk_o  (lane_blk[j])
        );
    end

    assign bus.KeyReady     = key_ready;
    assign bus.DataInReady  = (state_q == RUN);
    assign bus.DataOut      = lane_blk;
    assign bus.DataOutValid = &lane_vld;

endmodule

// File: tb/tb_aes_dw_ctr.sv
// Directed bench for aes_dw_ctr with an independent byte-level AES model.
module tb_aes_dw_ctr;
    localparam int W   = 4;
    localparam int D   = 12;
    localparam int IVW = 64;
    localparam int AW  = 128;
    localparam int BW  = W * AW;

    logic Clock = 1'b0;
    logic Reset = 1'b0;
    always #5 Clock = ~Clock;

    aes_dw_ctr_if #(.W(W), .IVEntropyWidth(IVW), .AESWidth(AW)) bus ();

    aes_dw_ctr #(.W(W), .D(D), .IVEntropyWidth(IVW), .AESWidth(AW)) dut (
        .Clock (Clock),
        .Reset (Reset),
        .bus   (bus.slave)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [BW-1:0] obs, input logic [BW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge Clock);
        #1;
    endtask

    // S-box derived from GF(2^8) inversion plus the affine map.
    logic [7:0] msb [256];

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (b[0]) p = p ^ a;
            a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
            b = b >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
        logic [7:0] r = b;
        for (int i = 0; i < n; i++) r = {r[6:0], r[7]};
        return r;
    endfunction

    task automatic build_sbox;
        logic [7:0] inv;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++)
                if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            msb[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
        end
    endtask

    function automatic logic [127:0] aes_model(input logic [127:0] key, input logic [127:0] pt);
        logic [7:0]   s [16];
        logic [7:0]   k [16];
        logic [7:0]   t [16];
        logic [7:0]   q0, q1, q2, q3, rc;
        logic [127:0] r;
        rc = 8'h01;
        for (int i = 0; i < 16; i++) begin
            k[i] = key[127-8*i -: 8];
            s[i] = pt[127-8*i -: 8] ^ k[i];
        end
        for (int rnd = 1; rnd <= 10; rnd++) begin
            q0 = msb[k[13]] ^ rc; q1 = msb[k[14]]; q2 = msb[k[15]]; q3 = msb[k[12]];
            k[0] ^= q0; k[1] ^= q1; k[2] ^= q2; k[3] ^= q3;
            for (int i = 4; i < 16; i++) k[i] ^= k[i-4];
            rc = gmul(rc, 8'h02);
            for (int i = 0; i < 16; i++) s[i] = msb[s[i]];
            for (int c = 0; c < 4; c++)
                for (int rr = 0; rr < 4; rr++) t[4*c+rr] = s[4*((c+rr)%4)+rr];
            for (int c = 0; c < 4; c++) begin
                if (rnd < 10) begin
                    s[4*c]   = gmul(t[4*c], 8'h02) ^ gmul(t[4*c+1], 8'h03) ^ t[4*c+2] ^ t[4*c+3];
                    s[4*c+1] = t[4*c] ^ gmul(t[4*c+1], 8'h02) ^ gmul(t[4*c+2], 8'h03) ^ t[4*c+3];
                    s[4*c+2] = t[4*c] ^ t[4*c+1] ^ gmul(t[4*c+2], 8'h02) ^ gmul(t[4*c+3], 8'h03);
                    s[4*c+3] = gmul(t[4*c], 8'h03) ^ t[4*c+1] ^ t[4*c+2] ^ gmul(t[4*c+3], 8'h02);
                end else begin
                    for (int rr = 0; rr < 4; rr++) s[4*c+rr] = t[4*c+rr];
                end
            end
            for (int i = 0; i < 16; i++) s[i] ^= k[i];
        end
        r = '0;
        for (int i = 0; i < 16; i++) r[127-8*i -: 8] = s[i];
        return r;
    endfunction

    function automatic logic [BW-1:0] pad(input logic [AW-1:0] key, input logic [IVW-1:0] iv);
        logic [BW-1:0] p = '0;
        for (int j = 0; j < W; j++) p[j*AW +: AW] = aes_model(key, {iv, 64'(j)});
        return p;
    endfunction

    localparam logic [127:0] KAT0 = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;

    logic [AW-1:0]  key_ones;
    logic [BW-1:0]  pad0;
    logic [IVW-1:0] ivs  [32];
    logic [BW-1:0]  exps [32];
    logic [IVW-1:0] ivs2 [16];
    logic [BW-1:0]  data [16];
    logic [BW-1:0]  ct   [16];

    initial begin
        bus.DataIn      = '0;
        bus.DataInValid = 1'b0;
        bus.Key         = '0;
        bus.KeyValid    = 1'b0;
        key_ones        = '1;
        build_sbox();
        chk("model_kat", BW'(aes_model('0, '0)), BW'(KAT0));
        pad0 = pad('0, '0);

        // Reset state and KeyReady rising one edge after release.
        repeat (3) tick();
        chk("rst_valid", BW'(bus.DataOutValid), BW'(1'b0));
        chk("rst_data", bus.DataOut, '0);
        chk("rst_dinrdy", BW'(bus.DataInReady), BW'(1'b0));
        chk("rst_keyrdy", BW'(bus.KeyReady), BW'(1'b0));
        Reset = 1'b1;
        chk("rel_keyrdy_pre", BW'(bus.KeyReady), BW'(1'b0));
        tick();
        chk("rel_keyrdy", BW'(bus.KeyReady), BW'(1'b1));
        chk("rel_dinrdy", BW'(bus.DataInReady), BW'(1'b0));

        // Zero key; IVs offered during expansion must vanish.
        bus.Key = '0;
        bus.KeyValid = 1'b1;
        tick();
        bus.KeyValid = 1'b0;
        chk("exp_keyrdy", BW'(bus.KeyReady), BW'(1'b0));
        for (int i = 1; i <= 10; i++) begin
            chk("exp_dinrdy", BW'(bus.DataInReady), BW'(1'b0));
            bus.DataInValid = 1'b1;
            bus.DataIn      = {$urandom, $urandom};
            tick();
        end
        chk("run_dinrdy", BW'(bus.DataInReady), BW'(1'b1));
        bus.DataIn = '0;
        tick();
        bus.DataInValid = 1'b0;
        for (int i = 1; i <= 19; i++) begin
            chk("kat_valid", BW'(bus.DataOutValid), BW'(i == 12));
            if (i == 12) begin
                chk("kat_lane0", BW'(bus.DataOut[AW-1:0]), BW'(KAT0));
                chk("kat_pad", bus.DataOut, pad0);
            end
            if (i == 14) chk("kat_hold", bus.DataOut, pad0);
            tick();
        end

        // All-ones key, 32 back-to-back IVs.
        Reset = 1'b0;
        tick(); tick();
        Reset = 1'b1;
        tick();
        chk("ones_keyrdy", BW'(bus.KeyReady), BW'(1'b1));
        bus.Key = key_ones;
        bus.KeyValid = 1'b1;
        tick();
        bus.KeyValid = 1'b0;
        repeat (10) tick();
        chk("ones_dinrdy", BW'(bus.DataInReady), BW'(1'b1));
        for (int i = 0; i < 32; i++) begin
            ivs[i]  = {$urandom, $urandom};
            exps[i] = pad(key_ones, ivs[i]);
        end
        for (int t = 0; t < 32 + D + 2; t++) begin
            if (t < 32) begin
                bus.DataInValid = 1'b1;
                bus.DataIn      = ivs[t];
            end else begin
                bus.DataInValid = 1'b0;
            end
            chk("stream_valid", BW'(bus.DataOutValid), BW'(t >= D && t < 32 + D));
            if (t >= D && t < 32 + D) chk("stream_data", bus.DataOut, exps[t-D]);
            if (t >= 32 + D) chk("stream_hold", bus.DataOut, exps[31]);
            tick();
        end

        // Same IV twice gives the same pad: XOR twice recovers the data.
        for (int i = 0; i < 16; i++) begin
            ivs2[i] = {$urandom, $urandom};
            for (int k = 0; k < W * 4; k++) data[i][k*32 +: 32] = $urandom;
        end
        for (int p = 0; p < 2; p++) begin
            for (int t = 0; t < 16 + D; t++) begin
                if (t < 16) begin
                    bus.DataInValid = 1'b1;
                    bus.DataIn      = ivs2[t];
                end else begin
                    bus.DataInValid = 1'b0;
                end
                if (t >= D) begin
                    chk("encdec_valid", BW'(bus.DataOutValid), BW'(1'b1));
                    if (p == 0) ct[t-D] = data[t-D] ^ bus.DataOut;
                    else        chk("encdec_data", ct[t-D] ^ bus.DataOut, data[t-D]);
                end
                tick();
            end
        end

        // Reset with 5 IVs in flight; nothing may emerge, key must be reloaded.
        for (int t = 0; t < 5; t++) begin
            bus.DataInValid = 1'b1;
            bus.DataIn      = ivs[t];
            tick();
        end
        bus.DataInValid = 1'b0;
        repeat (3) tick();
        Reset = 1'b0;
        #1;
        chk("mid_rst_valid", BW'(bus.DataOutValid), BW'(1'b0));
        chk("mid_rst_data", bus.DataOut, '0);
        chk("mid_rst_dinrdy", BW'(bus.DataInReady), BW'(1'b0));
        tick(); tick();
        chk("mid_rst_valid2", BW'(bus.DataOutValid), BW'(1'b0));
        Reset = 1'b1;
        chk("mid_keyrdy_pre", BW'(bus.KeyReady), BW'(1'b0));
        tick();
        chk("mid_keyrdy", BW'(bus.KeyReady), BW'(1'b1));
        for (int i = 0; i < 25; i++) begin
            bus.DataInValid = 1'b1;
            bus.DataIn      = {$urandom, $urandom};
            chk("nokey_valid", BW'(bus.DataOutValid), BW'(1'b0));
            chk("nokey_dinrdy", BW'(bus.DataInReady), BW'(1'b0));
            tick();
        end
        bus.DataInValid = 1'b0;
        bus.Key = key_ones;
        bus.KeyValid = 1'b1;
        tick();
        bus.KeyValid = 1'b0;
        for (int i = 0; i < 10; i++) begin
            chk("reload_valid", BW'(bus.DataOutValid), BW'(1'b0));
            tick();
        end
        chk("reload_dinrdy", BW'(bus.DataInReady), BW'(1'b1));
        bus.DataInValid = 1'b1;
        bus.DataIn      = ivs[0];
        tick();
        bus.DataInValid = 1'b0;
        for (int i = 1; i <= 12; i++) begin
            chk("reload_out_valid", BW'(bus.DataOutValid), BW'(i == 12));
            if (i == 12) chk("reload_out_data", bus.DataOut, exps[0]);
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
